// File: rtl/tpu_pkg.sv
// Shared defaults and state encoding for the systolic array output path.
package tpu_pkg;

  localparam int DEF_DIM = 32;
  localparam int DEF_DW  = 32;
  localparam int DEF_CW  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } deskew_state_t;

endpackage

// File: rtl/deskew_delay_line.sv
// Fixed-depth, always-shifting delay chain for one result column.
module deskew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
)(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      // The last column is already aligned, so clock and reset go unused here.
      logic w_unused;
      assign w_unused = clk_i ^ rst_i;
      assign q_o      = d_i;
    end else begin : g_chain
      logic [DW-1:0] r_stage [DEPTH];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign q_o = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_output_deskew.sv
// Realigns the skewed bottom-edge result stream into whole rows and tracks
// row progress through a tile.
module systolic_output_deskew
  import tpu_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int DW  = DEF_DW,
  parameter int CW  = DEF_CW
)(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CW-1:0]          num_rows_i,
  input  logic                   valid_i,
  input  logic [DIM-1:0][DW-1:0] data_i,
  output logic                   valid_o,
  output logic [DIM-1:0][DW-1:0] data_o,
  output logic [CW-1:0]          row_idx_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  logic [DIM-1:0][DW-1:0] w_tail;
  logic [DIM-1:0][DW-1:0] r_data;
  logic [DIM-1:0]         r_vld_line;
  logic [CW-1:0]          r_row_idx;
  logic [CW-1:0]          r_rows_left;
  logic                   r_overflow;
  logic                   w_last_row;
  deskew_state_t          r_state;
  deskew_state_t          w_state_next;

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_col
      deskew_delay_line #(
        .DEPTH (DIM - 1 - gi),
        .DW    (DW)
      ) u_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (data_i[gi]),
        .q_o   (w_tail[gi])
      );
    end
  endgenerate

  // Output register loads only when the valid line is about to present a row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_line <= '0;
      r_data     <= '0;
    end else begin
      r_vld_line <= {r_vld_line[DIM-2:0], valid_i};
      r_data     <= r_vld_line[DIM-2] ? w_tail : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_last_row   = 1'b0;
    case (r_state)
      IDLE:   if (start_i) w_state_next = ACTIVE;
      ACTIVE: begin
        if (valid_o && (r_rows_left == CW'(1))) begin
          w_last_row   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_row_idx   <= '0;
      r_rows_left <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (start_i) begin
          r_rows_left <= (num_rows_i == '0) ? CW'(1) : num_rows_i;
          r_row_idx   <= '0;
        end
        if (valid_o) r_overflow <= 1'b1;
      end else if (valid_o) begin
        r_row_idx   <= r_row_idx + CW'(1);
        r_rows_left <= r_rows_left - CW'(1);
      end
    end
  end

  assign valid_o    = r_vld_line[DIM-1];
  assign data_o     = r_data;
  assign busy_o     = (r_state == ACTIVE);
  assign done_o     = w_last_row;
  assign row_idx_o  = busy_o ? r_row_idx : '0;
  // A stray row is flagged in the very cycle it emerges.
  assign overflow_o = r_overflow | (~busy_o & valid_o);

endmodule
